// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int BCD_W          = 4;
    localparam int SCRATCH_DIGITS = 5;
    localparam int SCRATCH_W      = BCD_W * SCRATCH_DIGITS;
    localparam int unsigned MAX_DISP = 9999;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3 (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to 4-digit BCD converter, one input bit per clock.
// Define BIN2BCD_SATURATE_EN to show 9999 instead of bin mod 10000 on overflow.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [3:0]       bcd0,
    output logic [3:0]       bcd1,
    output logic [3:0]       bcd2,
    output logic [3:0]       bcd3,
    output logic             ovf
);

    localparam int CNT_W  = clog2(BIN_W + 1);
    localparam int DISP_W = BCD_W * DIGITS;

    if (DIGITS != 4) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS must be 4");
    end
    if (BIN_W < 10 || BIN_W > 16) begin : g_bad_width
        $error("bin2bcd_seq: BIN_W must be within 10..16");
    end

    state_e                 state_q, state_d;
    logic [BIN_W-1:0]       shreg_q, shreg_d;
    logic [SCRATCH_W-1:0]   scratch_q, scratch_d;
    logic [SCRATCH_W-1:0]   scratch_adj;
    logic [SCRATCH_W-1:0]   scratch_shifted;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_pend_q, ovf_pend_d;
    logic [DISP_W-1:0]      disp_q, disp_d;
    logic                   ovf_q, ovf_d;
    logic                   unused_scratch_msb;

    genvar gi;
    generate
        for (gi = 0; gi < SCRATCH_DIGITS; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .d_i(scratch_q[gi*BCD_W +: BCD_W]),
                .d_o(scratch_adj[gi*BCD_W +: BCD_W])
            );
        end
    endgenerate

    // The ten-thousands digit never exceeds 6, so its top bit is shifted out as zero.
    assign scratch_shifted    = {scratch_adj[SCRATCH_W-2:0], shreg_q[BIN_W-1]};
    assign unused_scratch_msb = scratch_adj[SCRATCH_W-1];

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d    = bin;
                    scratch_d  = '0;
                    cnt_d      = CNT_W'(BIN_W);
                    ovf_pend_d = 32'(bin) > MAX_DISP;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = scratch_shifted;
                shreg_d   = shreg_q << 1;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Results are registered on entry to DONE so they are valid with the done pulse.
                    state_d = DONE;
                    ovf_d   = ovf_pend_q;
`ifdef BIN2BCD_SATURATE_EN
                    disp_d  = ovf_pend_q ? {DIGITS{4'h9}} : scratch_shifted[DISP_W-1:0];
`else
                    disp_d  = scratch_shifted[DISP_W-1:0];
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign bcd0 = disp_q[0*BCD_W +: BCD_W];
    assign bcd1 = disp_q[1*BCD_W +: BCD_W];
    assign bcd2 = disp_q[2*BCD_W +: BCD_W];
    assign bcd3 = disp_q[3*BCD_W +: BCD_W];
    assign ovf  = ovf_q;

endmodule
